pe_array_ws: RTL and testbench
==============================

# pe_array_ws

Parametrised weight-stationary MAC array with its own load/execute/drain controller: NUM_ROW x NUM_COL processing cells, signed fixed-point multiply-accumulate. Input skew and output deskew are internal. Weights load row by row. Feature-map vectors stream in from the left, and one deskewed column-psum vector leaves the bottom per accepted input. It sits between the feature-map/weight buffers and the output accumulator buffer.

## Interface
- DATA_WIDTH, 16: signed operand width (fmap, weight).
- ACC_WIDTH, 40: signed psum/accumulator width, at least 2*DATA_WIDTH.
- NUM_ROW, 9: PE rows, which is also the input-vector length.
- NUM_COL, 8: PE columns, which is also the output-vector length.
- CNT_WIDTH, 16: width of the vector count.
- i_clk, in, 1: clock.
- i_rest_n, in, 1: reset. Asynchronous, active-low.
- start, in, 1: begin a job. Sampled only in IDLE.
- reuse_w, in, 1: sampled with start. When 1, skip LOAD and keep the resident weights.
- num_vec, in, CNT_WIDTH: number of fmap vectors in the job. Sampled with start.
- psum_f_top, in, NUM_COL*ACC_WIDTH: per-column bias. Latched at start. Column c occupies [c*ACC_WIDTH +: ACC_WIDTH].
- weight_top, in, NUM_COL*DATA_WIDTH: one weight row per beat.
- w_valid, in, 1 / w_ready, out, 1: weight handshake.
- i_fmap_left, in, NUM_ROW*DATA_WIDTH: one fmap vector. Row r occupies [r*DATA_WIDTH +: DATA_WIDTH].
- in_valid, in, 1 / in_ready, out, 1: fmap handshake.
- psum_t_down, out, NUM_COL*ACC_WIDTH: result vector.
- out_valid, out, 1: result qualifier. No backpressure.
- busy, out, 1: high whenever the state is not IDLE.
- done, out, 1: one-cycle pulse at job end.

## Operation
- States: IDLE, LOAD, EXE, DRAIN, DONE.
- IDLE:
  - start=1 latches reuse_w, num_vec and the bias.
  - Next state is LOAD if reuse_w=0, otherwise EXE.
  - start in any other state is ignored.
- LOAD:
  - w_ready=1.
  - Each w_valid&&w_ready beat writes weight_top into row row_cnt, starting at row 0.
  - After the beat for row NUM_ROW-1, go to EXE.
  - w_valid outside LOAD is ignored.
- num_vec=0: go straight to DONE after LOAD, or directly from IDLE when reuse_w=1. No out_valid is produced.
- EXE:
  - in_ready=1 while accepted count < num_vec.
  - Each accept injects the vector with a valid tag.
  - Bubbles (in_valid=0) propagate as invalid tags and produce no output.
  - On the accept that brings the count to num_vec, go to DRAIN.
- DRAIN:
  - Wait LAT cycles so the last result emerges, then go to DONE.
  - in_ready=0 and w_ready=0.
- DONE: done=1 for one cycle, then IDLE.
- Cell (r,c) behaviour:
  - Holds weight W[r][c].
  - Registers the fmap onward to (r,c+1).
  - Registers psum_out = psum_in + sext(fmap*W[r][c]).
  - psum_in for row 0 is bias[c].
  - The bottom row drives column c.
- Arithmetic:
  - The product is full 2*DATA_WIDTH signed, sign-extended to ACC_WIDTH.
  - Sums wrap in two's complement at ACC_WIDTH. No saturation.
- Skew: row r input is delayed r cycles.
- Deskew: column c output is delayed NUM_COL-1-c cycles.
- Result: psum_t_down[c] = bias[c] + sum over r of x[r]*W[r][c].

## Timing
- LAT = NUM_ROW + NUM_COL - 1, which is 16 at the defaults.
- A vector accepted at edge t gives out_valid=1 and its result in the cycle after edge t+LAT-1. All columns of that result are aligned in that cycle.
- Throughput: one vector per cycle. Results keep input order and preserve bubble gaps.
- Reset values: psum_t_down=0, out_valid=0, in_ready=0, w_ready=0, busy=0, done=0. State=IDLE, weights=0, all valid tags=0.
- Reset mid-job aborts immediately: pipeline tags and weights are cleared and no further out_valid appears. A following start with reuse_w=1 computes with zero weights, giving bias-only outputs.
- out_valid can still be high in DONE only if LAT has not fully elapsed. The DRAIN length guarantees the last out_valid occurs in the cycle before done.

## Structure
- Package pe_array_pkg holds:
  - the state enum;
  - a LAT function of NUM_ROW and NUM_COL;
  - default width localparams.
- Sub-module pe_mac_cell: one registered MAC cell with weight_en, fmap pass-through register and psum register, parametrised by DATA_WIDTH and ACC_WIDTH.
- The top level contains:
  - the FSM and counters;
  - skew/deskew shift registers;
  - the valid-tag pipeline;
  - a generate grid of cells.

## Test plan
- Reset: assert i_rest_n=0 mid-cycle → all outputs 0 asynchronously. busy stays 0 after release until start.
- Basic job: all weights 1, fmap all 2, bias 0, num_vec=1 → single out_valid 16 cycles after accept, every column 18, done the next cycle.
- Distinct columns: W[r][c]=c+1, x[r]=r, bias[c]=c, num_vec=4 streamed back-to-back → four consecutive results, column c = 36(c+1)+c.
- Bubbles and reuse_w: second job with reuse_w=1, in_valid pattern 1,0,0,1, x[r]=-1 → no LOAD beats. Two results separated by two idle cycles, column c = -9(c+1)+c.
- Wrap: ACC_WIDTH=32, DATA_WIDTH=16, all operands -32768, bias 0 → column = 9*2^30 mod 2^32, interpreted signed = 1073741824.
- Abort/edges: reset during EXE after 2 accepts → no out_valid and state IDLE. num_vec=0 → done 1 cycle after LOAD completes, no out_valid. start asserted while busy → ignored.

Source files
------------

// File: rtl/pe_array_pkg.sv
// rtl/pe_array_pkg.sv - shared states, default widths and latency helper for the weight-stationary MAC array
package pe_array_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ACC_WIDTH  = 40;
  localparam int DEF_NUM_ROW    = 9;
  localparam int DEF_NUM_COL    = 8;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXE   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } pe_state_e;

  // Edges from accepting a vector until its deskewed result is registered, plus one.
  function automatic int calc_lat(input int num_row, input int num_col);
    return num_row + num_col - 1;
  endfunction

endpackage

// File: rtl/pe_mac_cell.sv
// rtl/pe_mac_cell.sv - one registered signed MAC cell with stationary weight and fmap pass-through
module pe_mac_cell #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  weight_en,
  input  logic [DATA_WIDTH-1:0] weight_in,
  input  logic [DATA_WIDTH-1:0] fmap_in,
  input  logic [ACC_WIDTH-1:0]  psum_in,
  output logic [DATA_WIDTH-1:0] fmap_out,
  output logic [ACC_WIDTH-1:0]  psum_out
);

  logic signed [DATA_WIDTH-1:0]   weight_q;
  logic signed [2*DATA_WIDTH-1:0] product;

  // Full-width signed product; the size cast sign-extends it into the accumulator width.
  assign product = $signed(fmap_in) * weight_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      fmap_out <= '0;
      psum_out <= '0;
    end else begin
      if (weight_en) begin
        weight_q <= $signed(weight_in);
      end
      fmap_out <= fmap_in;
      psum_out <= psum_in + ACC_WIDTH'(product);
    end
  end

endmodule

// File: rtl/pe_array_ws.sv
// rtl/pe_array_ws.sv - weight-stationary MAC array with load/execute/drain control, skew and deskew
module pe_array_ws
  import pe_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int NUM_ROW    = DEF_NUM_ROW,
  parameter int NUM_COL    = DEF_NUM_COL,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                          i_clk,
  input  logic                          i_rest_n,
  input  logic                          start,
  input  logic                          reuse_w,
  input  logic [CNT_WIDTH-1:0]          num_vec,
  input  logic [NUM_COL*ACC_WIDTH-1:0]  psum_f_top,
  input  logic [NUM_COL*DATA_WIDTH-1:0] weight_top,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [NUM_ROW*DATA_WIDTH-1:0] i_fmap_left,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_COL*ACC_WIDTH-1:0]  psum_t_down,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int LAT       = calc_lat(NUM_ROW, NUM_COL);
  localparam int ROW_CNT_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1;
  localparam int DRN_CNT_W = $clog2(LAT + 1);

  pe_state_e                    state_q, state_d;
  logic [ROW_CNT_W-1:0]         row_cnt_q;
  logic [CNT_WIDTH-1:0]         vec_cnt_q;
  logic [CNT_WIDTH-1:0]         num_vec_q;
  logic [DRN_CNT_W-1:0]         drain_cnt_q;
  logic [NUM_COL*ACC_WIDTH-1:0] bias_q;
  logic [LAT-1:0]               tag_q;
  logic                         w_beat, accept, last_row, last_vec, drain_end;

  logic [DATA_WIDTH-1:0] fmap_src         [NUM_ROW];
  logic [DATA_WIDTH-1:0] fmap_h           [NUM_ROW][NUM_COL];
  logic [DATA_WIDTH-1:0] fmap_cell_out    [NUM_ROW][NUM_COL];
  logic [DATA_WIDTH-1:0] fmap_east_unused [NUM_ROW];
  logic [ACC_WIDTH-1:0]  psum_v           [NUM_ROW+1][NUM_COL];

  assign w_ready   = (state_q == ST_LOAD);
  assign in_ready  = (state_q == ST_EXE) && (vec_cnt_q < num_vec_q);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = tag_q[LAT-1];

  assign w_beat    = w_valid && w_ready;
  assign accept    = in_valid && in_ready;
  assign last_row  = (row_cnt_q == ROW_CNT_W'(NUM_ROW - 1));
  assign last_vec  = (vec_cnt_q == num_vec_q - CNT_WIDTH'(1));
  assign drain_end = (drain_cnt_q == DRN_CNT_W'(LAT - 1));

  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (!reuse_w) begin
            state_d = ST_LOAD;
          end else if (num_vec == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_EXE;
          end
        end
      end
      ST_LOAD: begin
        if (w_beat && last_row) begin
          state_d = (num_vec_q == '0) ? ST_DONE : ST_EXE;
        end
      end
      ST_EXE: begin
        if (accept && last_vec) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drain_end) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Job parameters are captured only when a start is actually taken in IDLE.
  always_ff @(posedge i_clk or negedge i_rest_n) begin
    if (!i_rest_n) begin
      row_cnt_q   <= '0;
      vec_cnt_q   <= '0;
      num_vec_q   <= '0;
      bias_q      <= '0;
      drain_cnt_q <= '0;
      tag_q       <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        row_cnt_q <= '0;
        vec_cnt_q <= '0;
        if (start) begin
          num_vec_q <= num_vec;
          bias_q    <= psum_f_top;
        end
      end else begin
        if (w_beat) begin
          row_cnt_q <= last_row ? '0 : row_cnt_q + ROW_CNT_W'(1);
        end
        if (accept) begin
          vec_cnt_q <= vec_cnt_q + CNT_WIDTH'(1);
        end
      end
      drain_cnt_q <= (state_q == ST_DRAIN) ? drain_cnt_q + DRN_CNT_W'(1) : '0;
      tag_q       <= {tag_q[LAT-2:0], accept};
    end
  end

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    // Bubbles inject zero data; only the tag pipeline decides what is a result.
    assign fmap_src[r]         = accept ? i_fmap_left[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign fmap_east_unused[r] = fmap_cell_out[r][NUM_COL-1];

    if (r == 0) begin : g_noskew
      assign fmap_h[0][0] = fmap_src[0];
    end else begin : g_skew
      logic [DATA_WIDTH-1:0] skew_q [r];
      always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
          for (int k = 0; k < r; k++) begin
            skew_q[k] <= '0;
          end
        end else begin
          skew_q[0] <= fmap_src[r];
          for (int k = 1; k < r; k++) begin
            skew_q[k] <= skew_q[k-1];
          end
        end
      end
      assign fmap_h[r][0] = skew_q[r-1];
    end

    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      if (c > 0) begin : g_east
        assign fmap_h[r][c] = fmap_cell_out[r][c-1];
      end
      if (r == 0) begin : g_bias
        assign psum_v[0][c] = bias_q[c*ACC_WIDTH +: ACC_WIDTH];
      end

      pe_mac_cell #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
      ) u_cell (
        .clk      (i_clk),
        .rst_n    (i_rest_n),
        .weight_en(w_beat && (row_cnt_q == ROW_CNT_W'(r))),
        .weight_in(weight_top[c*DATA_WIDTH +: DATA_WIDTH]),
        .fmap_in  (fmap_h[r][c]),
        .psum_in  (psum_v[r][c]),
        .fmap_out (fmap_cell_out[r][c]),
        .psum_out (psum_v[r+1][c])
      );
    end
  end

  // Column c leaves the grid c cycles after column 0, so it is held back NUM_COL-1-c cycles.
  for (genvar c = 0; c < NUM_COL; c++) begin : g_deskew
    localparam int DEPTH = NUM_COL - 1 - c;
    if (DEPTH == 0) begin : g_direct
      assign psum_t_down[c*ACC_WIDTH +: ACC_WIDTH] = psum_v[NUM_ROW][c];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] dsk_q [DEPTH];
      always_ff @(posedge i_clk or negedge i_rest_n) begin
        if (!i_rest_n) begin
          for (int k = 0; k < DEPTH; k++) begin
            dsk_q[k] <= '0;
          end
        end else begin
          dsk_q[0] <= psum_v[NUM_ROW][c];
          for (int k = 1; k < DEPTH; k++) begin
            dsk_q[k] <= dsk_q[k-1];
          end
        end
      end
      assign psum_t_down[c*ACC_WIDTH +: ACC_WIDTH] = dsk_q[DEPTH-1];
    end
  end

endmodule

// File: tb/tb_pe_array_ws.sv
// tb/tb_pe_array_ws.sv - directed table-driven bench for pe_array_ws
module tb_pe_array_ws;

  localparam int DW  = 16;
  localparam int AW  = 40;
  localparam int NR  = 9;
  localparam int NC  = 8;
  localparam int CW  = 16;
  localparam int LAT = NR + NC - 1;
  localparam int WAW = 32;

  // Vector record: x[r] = xa + xb*r, expected column c = ea + eb*c.
  typedef struct {
    bit     vld;
    int     xa;
    int     xb;
    longint ea;
    longint eb;
  } vec_t;

  logic              clk;
  logic              rst_n;
  logic              start, reuse_w, w_valid, w_ready, in_valid, in_ready;
  logic [CW-1:0]     num_vec;
  logic [NC*AW-1:0]  psum_f_top, psum_t_down;
  logic [NC*DW-1:0]  weight_top;
  logic [NR*DW-1:0]  i_fmap_left;
  logic              out_valid, busy, done;

  logic              wr_start, wr_reuse_w, wr_w_valid, wr_w_ready, wr_in_valid, wr_in_ready;
  logic [CW-1:0]     wr_num_vec;
  logic [NC*WAW-1:0] wr_psum_f_top, wr_psum_t_down;
  logic [NC*DW-1:0]  wr_weight_top;
  logic [NR*DW-1:0]  wr_fmap;
  logic              wr_out_valid, wr_busy, wr_done;

  int     n_checks = 0;
  int     n_errors = 0;
  int     cyc = 0;
  vec_t   tbl [8];
  int     tbl_n;
  int     wgt [NR][NC];
  longint bias_v [NC];
  int     acc_cyc [$];
  int     out_cyc [$];
  logic [NC*AW-1:0] out_dat [$];

  pe_array_ws #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .NUM_ROW(NR), .NUM_COL(NC), .CNT_WIDTH(CW)) u_dut (
    .i_clk(clk), .i_rest_n(rst_n), .start(start), .reuse_w(reuse_w), .num_vec(num_vec),
    .psum_f_top(psum_f_top), .weight_top(weight_top), .w_valid(w_valid), .w_ready(w_ready),
    .i_fmap_left(i_fmap_left), .in_valid(in_valid), .in_ready(in_ready),
    .psum_t_down(psum_t_down), .out_valid(out_valid), .busy(busy), .done(done)
  );

  pe_array_ws #(.DATA_WIDTH(DW), .ACC_WIDTH(WAW), .NUM_ROW(NR), .NUM_COL(NC), .CNT_WIDTH(CW)) u_wrap (
    .i_clk(clk), .i_rest_n(rst_n), .start(wr_start), .reuse_w(wr_reuse_w), .num_vec(wr_num_vec),
    .psum_f_top(wr_psum_f_top), .weight_top(wr_weight_top), .w_valid(wr_w_valid), .w_ready(wr_w_ready),
    .i_fmap_left(wr_fmap), .in_valid(wr_in_valid), .in_ready(wr_in_ready),
    .psum_t_down(wr_psum_t_down), .out_valid(wr_out_valid), .busy(wr_busy), .done(wr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      out_cyc.push_back(cyc);
      out_dat.push_back(psum_t_down);
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_q();
    acc_cyc.delete();
    out_cyc.delete();
    out_dat.delete();
  endtask

  task automatic start_job(input bit reuse, input int nv);
    start   = 1'b1;
    reuse_w = reuse;
    num_vec = CW'(nv);
    for (int c = 0; c < NC; c++) psum_f_top[c*AW +: AW] = AW'(bias_v[c]);
    @(negedge clk);
    start      = 1'b0;
    reuse_w    = 1'b0;
    num_vec    = '0;
    psum_f_top = '1;
  endtask

  task automatic load_w();
    logic rdy;
    for (int r = 0; r < NR; r++) begin
      w_valid = 1'b1;
      for (int c = 0; c < NC; c++) weight_top[c*DW +: DW] = DW'(wgt[r][c]);
      rdy = w_ready;
      @(negedge clk);
      check("w_ready_in_load", rdy, 1);
    end
    w_valid    = 1'b0;
    weight_top = '0;
  endtask

  task automatic stream_tbl();
    logic rdy;
    for (int i = 0; i < tbl_n; i++) begin
      in_valid = tbl[i].vld;
      for (int r = 0; r < NR; r++) i_fmap_left[r*DW +: DW] = DW'(tbl[i].xa + tbl[i].xb * r);
      rdy = in_ready;
      @(negedge clk);
      if (tbl[i].vld) begin
        check("in_ready_exe", rdy, 1);
        acc_cyc.push_back(cyc);
      end
    end
    in_valid    = 1'b0;
    i_fmap_left = '0;
  endtask

  task automatic wait_done(output int dcyc);
    dcyc = -1;
    for (int k = 0; k < 60; k++) begin
      if (done === 1'b1) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    check("done_seen", longint'(dcyc >= 0), 1);
  endtask

  task automatic check_outputs(input string tag);
    int nv = 0;
    int j  = 0;
    logic [NC*AW-1:0]    d;
    logic signed [AW-1:0] col;
    for (int i = 0; i < tbl_n; i++) if (tbl[i].vld) nv++;
    check({tag, "_out_count"}, out_cyc.size(), nv);
    for (int i = 0; i < tbl_n; i++) begin
      if (tbl[i].vld && j < out_cyc.size()) begin
        d = out_dat[j];
        for (int c = 0; c < NC; c++) begin
          col = d[c*AW +: AW];
          check($sformatf("%s_v%0d_col%0d", tag, j, c), longint'(col), tbl[i].ea + tbl[i].eb * c);
        end
        if (j < acc_cyc.size()) check({tag, "_latency"}, out_cyc[j] - acc_cyc[j], LAT - 1);
        j++;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int dcyc;
    logic found;
    logic [NC*WAW-1:0] wd;
    logic signed [WAW-1:0] wcol;

    rst_n = 1'b1;
    start = 0; reuse_w = 0; num_vec = '0; psum_f_top = '0; weight_top = '0;
    w_valid = 0; i_fmap_left = '0; in_valid = 0;
    wr_start = 0; wr_reuse_w = 0; wr_num_vec = '0; wr_psum_f_top = '0; wr_weight_top = '0;
    wr_w_valid = 0; wr_fmap = '0; wr_in_valid = 0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_w_ready", w_ready, 0);
    check("rst_psum_zero", longint'(psum_t_down == '0), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy_after_release", busy, 0);

    // Job 1: all weights 1, x=2, bias 0; a start during DRAIN must be ignored.
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) wgt[r][c] = 1;
    for (int c = 0; c < NC; c++) bias_v[c] = 0;
    tbl[0] = '{1, 2, 0, 18, 0};
    tbl_n  = 1;
    clear_q();
    start_job(0, 1);
    load_w();
    stream_tbl();
    start = 1'b1; num_vec = CW'(5);
    @(negedge clk);
    start = 1'b0; num_vec = '0;
    wait_done(dcyc);
    check_outputs("job1");
    if (out_cyc.size() > 0) check("job1_done_after_last", dcyc - out_cyc[out_cyc.size()-1], 1);
    @(negedge clk);
    check("job1_done_one_cycle", done, 0);
    repeat (3) @(negedge clk);
    check("busy_start_ignored", busy, 0);
    check("w_ready_start_ignored", w_ready, 0);

    // Job 2: W[r][c]=c+1, x[r]=r, bias[c]=c, four back-to-back vectors.
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) wgt[r][c] = c + 1;
    for (int c = 0; c < NC; c++) bias_v[c] = c;
    for (int i = 0; i < 4; i++) tbl[i] = '{1, 0, 1, 36, 37};
    tbl_n = 4;
    clear_q();
    start_job(0, 4);
    load_w();
    stream_tbl();
    wait_done(dcyc);
    check_outputs("job2");
    if (out_cyc.size() == 4) check("job2_back_to_back", out_cyc[3] - out_cyc[0], 3);
    @(negedge clk);

    // Job 3: resident weights, bubbles 1,0,0,1, x=-1.
    tbl[0] = '{1, -1, 0, -9, -8};
    tbl[1] = '{0,  0, 0,  0,  0};
    tbl[2] = '{0,  0, 0,  0,  0};
    tbl[3] = '{1, -1, 0, -9, -8};
    tbl_n  = 4;
    clear_q();
    start_job(1, 2);
    check("job3_no_load_w_ready", w_ready, 0);
    check("job3_exe_in_ready", in_ready, 1);
    stream_tbl();
    wait_done(dcyc);
    check_outputs("job3");
    if (out_cyc.size() == 2) check("job3_bubble_gap", out_cyc[1] - out_cyc[0], 3);
    @(negedge clk);

    // Abort: reset mid-EXE after two accepts.
    tbl[0] = '{1, 1, 0, 0, 0};
    tbl[1] = '{1, 1, 0, 0, 0};
    tbl_n  = 2;
    clear_q();
    start_job(1, 4);
    stream_tbl();
    #2 rst_n = 1'b0;
    #1;
    check("abort_psum_zero", longint'(psum_t_down == '0), 1);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    check("abort_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (25) @(negedge clk);
    check("abort_no_out_valid", out_cyc.size(), 0);
    check("abort_idle", busy, 0);

    // After abort the weights are zero: bias-only result.
    tbl[0] = '{1, 7, 0, 0, 1};
    tbl_n  = 1;
    clear_q();
    start_job(1, 1);
    stream_tbl();
    wait_done(dcyc);
    check_outputs("zero_w");
    @(negedge clk);

    // num_vec=0: DONE right after the last LOAD beat.
    for (int r = 0; r < NR; r++) for (int c = 0; c < NC; c++) wgt[r][c] = 1;
    clear_q();
    start_job(0, 0);
    load_w();
    check("nv0_done_after_load", done, 1);
    @(negedge clk);
    check("nv0_done_cleared", done, 0);
    check("nv0_idle", busy, 0);
    repeat (20) @(negedge clk);
    check("nv0_no_out_valid", out_cyc.size(), 0);

    // Wrap: 32-bit accumulator, all operands -32768.
    wr_start = 1'b1; wr_num_vec = CW'(1); wr_reuse_w = 1'b0; wr_psum_f_top = '0;
    @(negedge clk);
    wr_start = 1'b0; wr_num_vec = '0;
    for (int r = 0; r < NR; r++) begin
      wr_w_valid = 1'b1;
      wr_weight_top = {NC{16'h8000}};
      @(negedge clk);
    end
    wr_w_valid = 1'b0;
    wr_in_valid = 1'b1;
    wr_fmap = {NR{16'h8000}};
    @(negedge clk);
    wr_in_valid = 1'b0;
    found = 1'b0;
    wd = '0;
    for (int k = 0; k < 40; k++) begin
      if (wr_out_valid === 1'b1) begin
        found = 1'b1;
        wd = wr_psum_t_down;
        break;
      end
      @(negedge clk);
    end
    check("wrap_out_seen", found, 1);
    for (int c = 0; c < NC; c++) begin
      wcol = wd[c*WAW +: WAW];
      check($sformatf("wrap_col%0d", c), longint'(wcol), 1073741824);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
